sram_line_arbiter: RTL and testbench
====================================

// Module: sram_line_arbiter
// PURPOSE
//  Shares the single-port 32-bit user SRAM between the instruction-cache and data-cache refill paths of core0.
//  Each request is one 128-bit cache line: a read for either cache, or a write (writeback) for the dcache.
//  Latches the winner, sequences four 32-bit SRAM beats, packs/unpacks the line and returns a one-cycle ack.
//  Sits in the user project between core0.datapath caches and custom_sram.
// PARAMETERS
//  WADDR_W   9  SRAM word-address width (512 x 32-bit words); line address width is WADDR_W-2
//  READ_LAT  1  SRAM read latency in cycles, from the address cycle to the data-valid cycle (1..3)
// PORTS
//  wb_clk_i     in   1        clock
//  wb_rst_i     in   1        synchronous reset, active-high
//  ic_req_i     in   1        icache line-read request; held high until ic_ack_o
//  ic_addr_i    in   WADDR_W-2  icache line address
//  ic_ack_o     out  1        one-cycle pulse; ic_rdata_o valid in the same cycle
//  ic_rdata_o   out  128      icache line data; holds its value until the next icache grant
//  dc_req_i     in   1        dcache request; held high until dc_ack_o
//  dc_we_i      in   1        1 = line write, 0 = line read
//  dc_addr_i    in   WADDR_W-2  dcache line address
//  dc_wdata_i   in   128      dcache write line
//  dc_ack_o     out  1        one-cycle pulse; dc_rdata_o valid in the same cycle (reads)
//  dc_rdata_o   out  128      dcache read line; holds its value until the next dcache grant
//  sram_en_o    out  1        SRAM access enable (active-high)
//  sram_we_o    out  1        SRAM write enable
//  sram_addr_o  out  WADDR_W  SRAM word address
//  sram_wdata_o out  32       SRAM write data
//  sram_rdata_i in   32       SRAM read data, valid READ_LAT cycles after the address cycle
//  busy_o       out  1        high whenever the state is not IDLE
// BEHAVIOUR
//  - Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous and active-high.
//  - Reset values: all outputs 0, state IDLE, rdata registers 0, round-robin pointer set to dcache.
//  - States: IDLE -> BURST -> DRAIN (reads only) -> ACK -> GAP -> IDLE.
//  - IDLE, with any request sampled high at edge N:
//    - latch the winner, we, address and wdata;
//    - enter BURST for cycles N+1..N+4.
//  - BURST beat k (k = 0..3):
//    - sram_en_o = 1, sram_addr_o = {line_addr, k[1:0]};
//    - writes: sram_we_o = 1, sram_wdata_o = wdata[32k+31:32k].
//  - Reads: the beat-k data is captured at the end of cycle N+1+k+READ_LAT into line bits [32k+31:32k].
//    - DRAIN lasts READ_LAT cycles.
//  - Ack cycle: write -> N+5; read -> N+5+READ_LAT. Only the winner's ack rises.
//  - GAP is one cycle with both requests ignored; requesters drop req there. Back-to-back grants are therefore spaced by 1 cycle.
//  - Inputs after the grant: address and wdata changes after grant are ignored (latched at grant).
//    - A req that drops mid-transfer does not abort it; the ack is still issued.
//  - sram_en_o is 0 outside BURST; sram_we_o and sram_wdata_o are 0 when sram_en_o = 0.
//  - Simultaneous ic_req_i and dc_req_i in IDLE: resolved by the arbitration policy (CONFIGURATION).
//  - Reset mid-transfer: the transfer is abandoned, no ack, SRAM disabled in the next cycle, all state per the reset values.
//  - An ic write does not exist; dc_we_i is ignored for the icache port.
// CONFIGURATION
//  - Macro SRAM_ARB_ROUND_ROBIN_EN.
//  - Defined: round-robin arbitration. On a tie the grant goes to the port not granted last; the pointer updates at each grant.
//  - Undefined: fixed priority, dcache always wins a tie. The pointer register is not built.
// TESTING
//  1. Reset check: assert reset -> all outputs 0, busy_o = 0. Then a dc write of line 0x05, data 128'h33FF00FF33 -> sram_addr_o 0x14..0x17 on 4 consecutive cycles, first beat 32'hFF00FF33, second 32'h00000033, dc_ack_o in cycle N+5.
//  2. dc read of line 0x05 after test 1 (READ_LAT = 1) -> dc_rdata_o[39:0] = 40'h33FF00FF33, dc_ack_o in cycle N+6, ic_ack_o stays 0.
//  3. ic read of line 0x00 with SRAM words 0..3 = 1,2,3,4 -> ic_rdata_o = {32'd4,32'd3,32'd2,32'd1}.
//  4. ic and dc requests raised in the same cycle, 3 times in a row:
//     - with SRAM_ARB_ROUND_ROBIN_EN: grants dc, ic, dc;
//     - without it: grants dc, dc, dc, with ic starved while dc is held high.
//  5. Assert wb_rst_i during beat 2 of a dc write -> no dc_ack_o, sram_en_o = 0 next cycle, a new ic request then completes normally.
//  6. Hold dc_req_i high through the ack -> GAP cycle observed, second grant starts exactly 2 cycles after the ack.

Source files
------------

// File: rtl/sram_line_arbiter.sv
// Arbitrates icache/dcache 128-bit line requests onto a single-port 32-bit SRAM in four beats.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties (default: dcache wins ties).
module sram_line_arbiter #(
    parameter int unsigned WADDR_W  = 9,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 ic_req_i,
    input  logic [WADDR_W-3:0]   ic_addr_i,
    output logic                 ic_ack_o,
    output logic [127:0]         ic_rdata_o,
    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [WADDR_W-3:0]   dc_addr_i,
    input  logic [127:0]         dc_wdata_i,
    output logic                 dc_ack_o,
    output logic [127:0]         dc_rdata_o,
    output logic                 sram_en_o,
    output logic                 sram_we_o,
    output logic [WADDR_W-1:0]   sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    input  logic [31:0]          sram_rdata_i,
    output logic                 busy_o
);
    typedef enum logic [2:0] {StIdle, StBurst, StDrain, StAck, StGap} state_e;

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 win_dc_q;
    logic                 we_q;
    logic [WADDR_W-3:0]   addr_q;
    logic [127:0]         wdata_q;
    logic [127:0]         ic_rdata_q, dc_rdata_q;
    logic [READ_LAT-1:0]  rd_vld_q;
    logic [1:0]           rd_idx_q [READ_LAT];
    logic                 grant, grant_dc, rd_issue;
    logic [6:0]           beat_lsb, cap_lsb;

    assign grant = ic_req_i | dc_req_i;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // prio_dc_q = 1 means the dcache wins the next tie.
    logic prio_dc_q;
    assign grant_dc = dc_req_i && (!ic_req_i || prio_dc_q);
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prio_dc_q <= 1'b1;
        end else if (state_q == StIdle && grant) begin
            prio_dc_q <= !grant_dc;
        end
    end
`else
    assign grant_dc = dc_req_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StBurst;
                    cnt_d   = 2'd0;
                end
            end
            StBurst: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = we_q ? StAck : StDrain;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(READ_LAT - 1)) begin
                    cnt_d   = 2'd0;
                    state_d = StAck;
                end
            end
            StAck:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            win_dc_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && grant) begin
                win_dc_q <= grant_dc;
                we_q     <= grant_dc & dc_we_i;
                addr_q   <= grant_dc ? dc_addr_i : ic_addr_i;
                wdata_q  <= dc_wdata_i;
            end
        end
    end

    // Tracks which beat's data arrives READ_LAT cycles after its address cycle.
    assign rd_issue = (state_q == StBurst) && !we_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rd_vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) rd_idx_q[i] <= 2'd0;
        end else begin
            rd_vld_q[0] <= rd_issue;
            rd_idx_q[0] <= cnt_q;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_idx_q[i] <= rd_idx_q[i-1];
            end
        end
    end

    assign cap_lsb = {rd_idx_q[READ_LAT-1], 5'd0};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else if (rd_vld_q[READ_LAT-1]) begin
            if (win_dc_q) dc_rdata_q[cap_lsb +: 32] <= sram_rdata_i;
            else          ic_rdata_q[cap_lsb +: 32] <= sram_rdata_i;
        end
    end

    assign beat_lsb     = {cnt_q, 5'd0};
    assign sram_en_o    = (state_q == StBurst);
    assign sram_we_o    = sram_en_o & we_q;
    assign sram_addr_o  = sram_en_o ? {addr_q, cnt_q} : '0;
    assign sram_wdata_o = sram_we_o ? wdata_q[beat_lsb +: 32] : 32'd0;
    assign ic_ack_o     = (state_q == StAck) && !win_dc_q;
    assign dc_ack_o     = (state_q == StAck) && win_dc_q;
    assign ic_rdata_o   = ic_rdata_q;
    assign dc_rdata_o   = dc_rdata_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_sram_line_arbiter.sv
// Bench for sram_line_arbiter: directed vector table, hand sequences, random line traffic
// against a line-level memory model with a behavioural SRAM.
module tb_sram_line_arbiter;
    localparam int unsigned WADDR_W  = 9;
    localparam int unsigned READ_LAT = 1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0;
    logic [6:0]   ic_addr = '0, dc_addr = '0;
    logic [127:0] dc_wdata = '0;
    logic         ic_ack, dc_ack, sram_en, sram_we, busy;
    logic [127:0] ic_rdata, dc_rdata;
    logic [8:0]   sram_addr;
    logic [31:0]  sram_wdata, sram_rdata;

    sram_line_arbiter #(.WADDR_W(WADDR_W), .READ_LAT(READ_LAT)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_ack_o(ic_ack), .ic_rdata_o(ic_rdata),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
        .dc_ack_o(dc_ack), .dc_rdata_o(dc_rdata),
        .sram_en_o(sram_en), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM with READ_LAT-cycle read latency.
    logic [31:0] mem [512];
    logic [31:0] rpipe [READ_LAT];
    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        rpipe[0] <= (sram_en && !sram_we) ? mem[sram_addr] : 32'd0;
        for (int i = 1; i < READ_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign sram_rdata = rpipe[READ_LAT-1];

    int checks = 0;
    int failures = 0;

    // Line-level reference model.
    logic [127:0] ref_mem [128];
    logic [127:0] m_ic_rd = '0, m_dc_rd = '0;
    bit           m_last_dc = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] cv(input bit b, input bit en, input bit we, input bit ica,
                                        input bit dca, input logic [8:0] a, input logic [31:0] wd);
        return {82'd0, b, en, we, ica, dca, a, wd};
    endfunction

    function automatic logic [127:0] act_cv();
        return cv(busy, sram_en, sram_we, ic_ack, dc_ack, sram_addr, sram_wdata);
    endfunction

    function automatic bit tie_dc();
        return RrEn ? !m_last_dc : 1'b1;
    endfunction

    // Entered at a sample point of an IDLE cycle; the grant happens at this cycle's end.
    task automatic do_txn(input string name, input bit ic_on, input bit dc_on, input bit we,
                          input logic [6:0] ic_a, input logic [6:0] dc_a,
                          input logic [127:0] wd, input bit hold, output bit won_dc);
        bit wdc, ewe;
        logic [6:0] line;
        int ack_c;
        logic [127:0] exp;
        wdc   = dc_on && (!ic_on || tie_dc());
        ewe   = wdc && we;
        line  = wdc ? dc_a : ic_a;
        ack_c = ewe ? 5 : 5 + READ_LAT;
        ic_req = ic_on; dc_req = dc_on; dc_we = we;
        ic_addr = ic_a; dc_addr = dc_a; dc_wdata = wd;
        won_dc = 1'b0;
        for (int c = 1; c <= ack_c; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                ic_addr  = 7'($urandom);
                dc_addr  = 7'($urandom);
                dc_wdata = {$urandom, $urandom, $urandom, $urandom};
                dc_we    = 1'($urandom);
            end
            if (c <= 4)
                exp = cv(1, 1, ewe, 0, 0, {line, 2'(c - 1)}, ewe ? wd[(c-1)*32 +: 32] : 32'd0);
            else
                exp = cv(1, 0, 0, (c == ack_c) && !wdc, (c == ack_c) && wdc, 9'd0, 32'd0);
            chk($sformatf("%s cyc%0d", name, c), act_cv(), exp);
            if (c == ack_c) won_dc = dc_ack;
        end
        if (ewe)      ref_mem[line] = wd;
        else if (wdc) m_dc_rd = ref_mem[line];
        else          m_ic_rd = ref_mem[line];
        m_last_dc = wdc;
        chk({name, " ic_rdata"}, ic_rdata, m_ic_rd);
        chk({name, " dc_rdata"}, dc_rdata, m_dc_rd);
        if (!hold) begin
            ic_req = 1'b0; dc_req = 1'b0;
            @(posedge clk); #1;
            chk({name, " gap"}, act_cv(), cv(1, 0, 0, 0, 0, 9'd0, 32'd0));
            @(posedge clk); #1;
            chk({name, " idle"}, act_cv(), cv(0, 0, 0, 0, 0, 9'd0, 32'd0));
        end
    endtask

    typedef struct {
        bit           ic_on;
        bit           dc_on;
        bit           we;
        logic [6:0]   ic_a;
        logic [6:0]   dc_a;
        logic [127:0] wd;
        bit           chk_rd;
        logic [127:0] exp_rd;
        bit           exp_dc;
    } vec_t;

    vec_t vt[8];

    initial begin
        bit w;
        int n;
        logic [127:0] wd;
        logic [127:0] line0 = {32'd4, 32'd3, 32'd2, 32'd1};
        logic [127:0] pat5  = 128'h33FF00FF33;

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 128'd0;
        for (int i = 0; i < READ_LAT; i++) rpipe[i] = 32'd0;

        vt[0] = '{0, 1, 1, 7'h00, 7'h05, pat5,  0, 128'd0, 1};
        vt[1] = '{0, 1, 0, 7'h00, 7'h05, '0,    1, pat5,   1};
        vt[2] = '{0, 1, 1, 7'h00, 7'h00, line0, 0, 128'd0, 1};
        vt[3] = '{1, 0, 0, 7'h00, 7'h00, '0,    1, line0,  0};
        vt[4] = '{1, 0, 0, 7'h05, 7'h00, '0,    1, pat5,   0};
        vt[5] = '{1, 1, 0, 7'h00, 7'h05, '0,    0, 128'd0, 1};
        vt[6] = '{1, 1, 0, 7'h00, 7'h05, '0,    0, 128'd0, !RrEn};
        vt[7] = '{1, 1, 0, 7'h00, 7'h05, '0,    0, 128'd0, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctrl", act_cv(), cv(0, 0, 0, 0, 0, 9'd0, 32'd0));
        chk("reset ic_rdata", ic_rdata, 128'd0);
        chk("reset dc_rdata", dc_rdata, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("vec%0d", i), vt[i].ic_on, vt[i].dc_on, vt[i].we,
                   vt[i].ic_a, vt[i].dc_a, vt[i].wd, 1'b0, w);
            chk($sformatf("vec%0d winner_dc", i), 128'(w), 128'(vt[i].exp_dc));
            if (vt[i].chk_rd)
                chk($sformatf("vec%0d rdata", i), vt[i].ic_on ? ic_rdata : dc_rdata, vt[i].exp_rd);
        end

        // Reset during beat 2 of a dcache write.
        wd = {$urandom, $urandom, $urandom, $urandom};
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 7'h2A; dc_wdata = wd;
        repeat (3) @(posedge clk);
        #1;
        chk("rst beat2", act_cv(), cv(1, 1, 1, 0, 0, {7'h2A, 2'd2}, wd[95:64]));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst ctrl", act_cv(), cv(0, 0, 0, 0, 0, 9'd0, 32'd0));
        chk("rst dc_rdata", dc_rdata, 128'd0);
        rst = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        // Beats 0..2 reached the SRAM before the reset took effect.
        ref_mem[7'h2A][95:0] = wd[95:0];
        m_ic_rd = '0; m_dc_rd = '0; m_last_dc = 1'b0;
        do_txn("post_rst ic", 1, 0, 0, 7'h2A, 7'h00, '0, 1'b0, w);

        // dc_req held through the ack: GAP, IDLE, then the next burst.
        do_txn("hold first", 0, 1, 0, 7'h00, 7'h05, '0, 1'b1, w);
        dc_addr = 7'h05; dc_we = 1'b0;
        @(posedge clk); #1;
        chk("hold gap", act_cv(), cv(1, 0, 0, 0, 0, 9'd0, 32'd0));
        @(posedge clk); #1;
        chk("hold idle", act_cv(), cv(0, 0, 0, 0, 0, 9'd0, 32'd0));
        @(posedge clk); #1;
        chk("hold beat0", act_cv(), cv(1, 1, 0, 0, 0, {7'h05, 2'd0}, 32'd0));
        n = 1;
        while (!dc_ack && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold ack latency", 128'(n), 128'(5 + READ_LAT));
        dc_req = 1'b0;
        m_dc_rd = ref_mem[7'h05];
        m_last_dc = 1'b1;
        chk("hold dc_rdata", dc_rdata, m_dc_rd);
        repeat (2) @(posedge clk);
        #1;
        chk("hold idle2", act_cv(), cv(0, 0, 0, 0, 0, 9'd0, 32'd0));

        // Random traffic against the line model.
        for (int i = 0; i < 40; i++) begin
            bit ic_on, dc_on;
            ic_on = 1'($urandom);
            dc_on = 1'($urandom);
            if (!ic_on && !dc_on) dc_on = 1'b1;
            do_txn($sformatf("rnd%0d", i), ic_on, dc_on, 1'($urandom),
                   7'($urandom), 7'($urandom), {$urandom, $urandom, $urandom, $urandom},
                   1'b0, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
